// File: rtl/elbeth_definitions.sv
// Shared encodings for the Elbeth instruction/data memory arbiter.
// Holds the FSM state encoding and the grant (which port owns the memory) encoding.
package elbeth_definitions;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_t;

endpackage

// File: rtl/elbeth_arb_timeout.sv
// Access timeout counter for the memory arbiter.
// Counts waiting cycles while enabled and flags the final permitted cycle.
module elbeth_arb_timeout
  import elbeth_definitions::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Expiry marks the last ACCESS cycle, so mem_en stays up exactly TIMEOUT cycles.
  assign o_expired = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/elbeth_memory_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the instruction
// and data ports, with registered requests, registered responses and a timeout.
module elbeth_memory_arbiter
  import elbeth_definitions::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              imem_en,
  input  logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_in_data,
  output logic              imem_ready,
  output logic              imem_error,
  input  logic              dmem_en,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_out_data,
  input  logic [3:0]        dmem_rw,
  output logic [31:0]       dmem_in_data,
  output logic              dmem_ready,
  output logic              dmem_error,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_out_data,
  output logic [3:0]        mem_rw,
  input  logic [31:0]       mem_in_data,
  input  logic              mem_ready,
  input  logic              mem_error
);

  arb_state_t        r_state;
  arb_grant_t        r_grant;
  arb_grant_t        r_lastGrant;
  arb_grant_t        w_winner;
  logic              r_memEn;
  logic [ADDR_W-1:0] r_memAddr;
  logic [31:0]       r_memOutData;
  logic [3:0]        r_memRw;
  logic [31:0]       r_imemData;
  logic [31:0]       r_dmemData;
  logic              r_imemReady;
  logic              r_imemError;
  logic              r_dmemReady;
  logic              r_dmemError;
  logic              w_expired;
  logic              w_cntClear;
  logic              w_cntEnable;
  logic              w_done;
  logic              w_respError;
  logic [31:0]       w_respData;

  // On a tie the port that did not win last time gets the memory.
  always_comb begin
    w_winner = r_lastGrant;
    if (imem_en && dmem_en) begin
      w_winner = (r_lastGrant == GNT_D) ? GNT_I : GNT_D;
    end else if (imem_en) begin
      w_winner = GNT_I;
    end else if (dmem_en) begin
      w_winner = GNT_D;
    end
  end

  assign w_cntClear  = (r_state == ARB_IDLE);
  assign w_cntEnable = (r_state == ARB_ACCESS) && !mem_ready && !mem_error && !w_expired;

  elbeth_arb_timeout #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_cntClear),
    .i_enable (w_cntEnable),
    .o_expired(w_expired)
  );

  // A fault or timeout without mem_ready returns zero data flagged as an error.
  assign w_done      = mem_ready || mem_error || w_expired;
  assign w_respData  = mem_ready ? mem_in_data : 32'h0;
  assign w_respError = mem_ready ? mem_error : 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_grant      <= GNT_I;
      r_lastGrant  <= GNT_D;
      r_memEn      <= 1'b0;
      r_memAddr    <= '0;
      r_memOutData <= 32'h0;
      r_memRw      <= 4'h0;
      r_imemData   <= 32'h0;
      r_dmemData   <= 32'h0;
      r_imemReady  <= 1'b0;
      r_imemError  <= 1'b0;
      r_dmemReady  <= 1'b0;
      r_dmemError  <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (imem_en || dmem_en) begin
            r_grant     <= w_winner;
            r_lastGrant <= w_winner;
            r_memEn     <= 1'b1;
            r_state     <= ARB_ACCESS;
            if (w_winner == GNT_D) begin
              r_memAddr    <= dmem_addr;
              r_memOutData <= dmem_out_data;
              r_memRw      <= dmem_rw;
            end else begin
              r_memAddr    <= imem_addr;
              r_memOutData <= 32'h0;
              r_memRw      <= 4'h0;
            end
          end
        end
        ARB_ACCESS: begin
          if (w_done) begin
            r_memEn <= 1'b0;
            r_state <= ARB_RESP;
            if (r_grant == GNT_D) begin
              r_dmemData  <= w_respData;
              r_dmemError <= w_respError;
              r_dmemReady <= 1'b1;
            end else begin
              r_imemData  <= w_respData;
              r_imemError <= w_respError;
              r_imemReady <= 1'b1;
            end
          end
        end
        ARB_RESP: begin
          r_imemReady <= 1'b0;
          r_imemError <= 1'b0;
          r_dmemReady <= 1'b0;
          r_dmemError <= 1'b0;
          r_state     <= ARB_IDLE;
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign mem_en       = r_memEn;
  assign mem_addr     = r_memAddr;
  assign mem_out_data = r_memOutData;
  assign mem_rw       = r_memRw;
  assign imem_in_data = r_imemData;
  assign imem_ready   = r_imemReady;
  assign imem_error   = r_imemError;
  assign dmem_in_data = r_dmemData;
  assign dmem_ready   = r_dmemReady;
  assign dmem_error   = r_dmemError;

endmodule
